// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter and the data memory.
// Also holds the address-window check used at grant time.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [31:0] DEF_BASE_ADR   = 32'd1024;
  localparam int unsigned DEF_WORD_COUNT = 64;

  // Evaluated in 33 bits so a window that ends exactly at 2^32 does not wrap.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned words);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    hi = lo + (33'(words) << 2);
    a  = {1'b0, adr};
    return (a >= lo) && (a < hi) && (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port combinational arbiter: a lone requester wins; ties go to port 0
// under fixed priority, otherwise to the port that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       lastGnt,
  input  logic       fixedPrio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixedPrio || lastGnt) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port 0) and
// the DMA/debug loader (port 1), one access at a time via IDLE/ACCESS/RESP.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = DEF_BASE_ADR,
  parameter int unsigned WORD_COUNT = DEF_WORD_COUNT,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] adr0,
  input  logic [31:0] adr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] memAdr,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] readData
);

  state_t      state_q;
  state_t      state_d;
  logic        last_gnt_q;
  logic        id_q;
  logic        we_q;
  logic        in_range_q;
  logic [1:0]  gnt;
  logic        gnt_id;
  logic        sel_we;
  logic [31:0] sel_adr;
  logic [31:0] sel_wdata;
  logic        grant;

  rr_arbiter2 u_arb (
    .req       (req),
    .lastGnt   (last_gnt_q),
    .fixedPrio (FIXED_PRIO),
    .gnt       (gnt)
  );

  assign gnt_id    = gnt[1];
  assign sel_we    = we[gnt_id];
  assign sel_adr   = gnt_id ? adr1 : adr0;
  assign sel_wdata = gnt_id ? wdata1 : wdata0;
  assign grant     = (state_q == IDLE) && (req != 2'b00);

  always_comb begin
    state_d  = state_q;
    ack      = 2'b00;
    memRead  = 1'b0;
    memWrite = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (req != 2'b00) state_d = ACCESS;
      end
      ACCESS: begin
        memRead  = in_range_q & ~we_q;
        memWrite = in_range_q & we_q;
        state_d  = RESP;
      end
      RESP: begin
        ack     = (id_q == PORT_DMA) ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // lastGnt resets to port 1 so the first tie after reset goes to port 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= PORT_DMA;
      id_q       <= PORT_CPU;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      memAdr     <= '0;
      writeData  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q       <= gnt_id;
        last_gnt_q <= gnt_id;
        we_q       <= sel_we;
        memAdr     <= sel_adr;
        writeData  <= sel_wdata;
        in_range_q <= in_window(sel_adr, BASE_ADR, WORD_COUNT);
      end
      if (state_q == ACCESS) begin
        rdata <= (in_range_q && !we_q) ? readData : 32'd0;
        err   <= ~in_range_q;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random
// single-port traffic checked against a word-array reference model.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          WORDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] adr0 = '0, adr1 = '0, wdata0 = '0, wdata1 = '0;

  logic [1:0]  ack, ack_f;
  logic        err, err_f, busy, busy_f;
  logic [31:0] rdata, rdata_f, memAdr, memAdr_f, writeData, writeData_f;
  logic        memRead, memRead_f, memWrite, memWrite_f;
  logic [31:0] readData, readData_f;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic        model_last = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'd63);
  endfunction

  function automatic bit ref_ok(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= 1024) && (la < 1024 + 4 * WORDS) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic w, input logic [31:0] a);
    return (ref_ok(a) && !w) ? ref_mem[widx(a)] : 32'd0;
  endfunction

  assign readData   = mem[widx(memAdr)];
  assign readData_f = mem[widx(memAdr_f)];

  always @(negedge clk) if (memWrite) mem[widx(memAdr)] <= writeData;

  data_mem_arbiter #(.BASE_ADR(BASE), .WORD_COUNT(WORDS), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr0(adr0), .adr1(adr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .memAdr(memAdr), .writeData(writeData), .memRead(memRead),
    .memWrite(memWrite), .readData(readData));

  data_mem_arbiter #(.BASE_ADR(BASE), .WORD_COUNT(WORDS), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr0(adr0), .adr1(adr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack_f), .err(err_f), .rdata(rdata_f),
    .busy(busy_f), .memAdr(memAdr_f), .writeData(writeData_f), .memRead(memRead_f),
    .memWrite(memWrite_f), .readData(readData_f));

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
    $fatal(1, "timeout");
  end

  // Drives one single-port request and returns what was observed.
  task automatic run_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [1:0] av, output logic ev, output logic [31:0] rv,
                         output int cyc, output int nrd, output int nwr);
    @(negedge clk);
    req = 2'b00; req[p] = 1'b1; we[p] = w;
    if (p == 0) begin adr0 = a; wdata0 = d; end
    else        begin adr1 = a; wdata1 = d; end
    cyc = 1; nrd = 0; nwr = 0; av = 2'b00; ev = 1'b0; rv = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cyc++;
      if (memRead)  nrd++;
      if (memWrite) nwr++;
      if (ack != 2'b00) begin av = ack; ev = err; rv = rdata; break; end
    end
    req = 2'b00;
  endtask

  task automatic test_reset();
    int cyc;
    logic [1:0] first;
    #12;
    checks++;
    if ({ack, err, rdata, busy, memAdr, writeData, memRead, memWrite} !== '0) begin
      errors++; $display("FAIL reset_outputs: ack=%b err=%b rdata=%h busy=%b memAdr=%h, required all zero", ack, err, rdata, busy, memAdr);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); req = 2'b01; we = 2'b00; adr0 = 32'd1028;
    @(posedge clk); #2;
    checks++;
    if (memRead !== 1'b1) begin errors++; $display("FAIL reset_pre_read: memRead=%b required 1", memRead); end
    rst = 1'b0;
    #1;
    checks++;
    if ({ack, err, rdata, busy, memAdr, memRead, memWrite} !== '0) begin
      errors++; $display("FAIL reset_async: ack=%b busy=%b memRead=%b memAdr=%h, required all zero", ack, busy, memRead, memAdr);
    end
    req = 2'b00;
    @(negedge clk); rst = 1'b1;
    model_last = 1'b1;
    @(negedge clk); req = 2'b11; adr0 = 32'd1028; adr1 = 32'd1032; cyc = 1; first = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); cyc++;
      if (ack != 2'b00) begin first = ack; break; end
    end
    req = 2'b00;
    checks++;
    if (first !== 2'b01 || cyc != 3) begin
      errors++; $display("FAIL reset_first_tie: ack=%b cycle=%0d, required ack=01 cycle=3", first, cyc);
    end
    model_last = PORT_CPU;
  endtask

  task automatic test_single_load();
    logic [1:0] av; logic ev; logic [31:0] rv; int cyc, nrd, nwr;
    run_txn(0, 1'b0, 32'd1028, 32'd0, av, ev, rv, cyc, nrd, nwr);
    model_last = 1'b0;
    checks++;
    if (av !== 2'b01 || cyc != 3) begin errors++; $display("FAIL load_ack: ack=%b cycle=%0d, required 01 at 3", av, cyc); end
    checks++;
    if (rv !== 32'hDEADBEEF || ev !== 1'b0) begin errors++; $display("FAIL load_data: rdata=%h err=%b, required DEADBEEF err=0", rv, ev); end
    checks++;
    if (nrd != 1 || nwr != 0) begin errors++; $display("FAIL load_strobes: reads=%0d writes=%0d, required 1/0", nrd, nwr); end
  endtask

  task automatic test_store_load();
    logic [1:0] av; logic ev; logic [31:0] rv; int cyc, nrd, nwr;
    run_txn(1, 1'b1, 32'd1100, 32'h12345678, av, ev, rv, cyc, nrd, nwr);
    ref_mem[widx(32'd1100)] = 32'h12345678; model_last = 1'b1;
    checks++;
    if (av !== 2'b10 || ev !== 1'b0 || nwr != 1 || nrd != 0) begin
      errors++; $display("FAIL store_ack: ack=%b err=%b writes=%0d reads=%0d, required 10/0/1/0", av, ev, nwr, nrd);
    end
    run_txn(0, 1'b0, 32'd1100, 32'd0, av, ev, rv, cyc, nrd, nwr);
    model_last = 1'b0;
    checks++;
    if (av !== 2'b01 || rv !== 32'h12345678) begin
      errors++; $display("FAIL store_readback: ack=%b rdata=%h, required 01 12345678", av, rv);
    end
  endtask

  task automatic test_range();
    logic [31:0] adrs [6];
    logic [1:0] av; logic ev; logic [31:0] rv; int cyc, nrd, nwr;
    logic w; int p;
    adrs = '{32'd1020, 32'd1280, 32'd1026, 32'd1276, 32'hFFFF_FFFC, 32'd1024};
    for (int i = 0; i < 6; i++) begin
      w = logic'(i % 2); p = (i / 2) % 2;
      run_txn(p, w, adrs[i], 32'hCAFE0000 + 32'(i), av, ev, rv, cyc, nrd, nwr);
      checks++;
      if (av !== (p == 0 ? 2'b01 : 2'b10) || ev !== !ref_ok(adrs[i]) || rv !== ref_load(w, adrs[i])
          || nrd != ((ref_ok(adrs[i]) && !w) ? 1 : 0) || nwr != ((ref_ok(adrs[i]) && w) ? 1 : 0)) begin
        errors++; $display("FAIL range_%0d adr=%0d: ack=%b err=%b rdata=%h rd=%0d wr=%0d, required err=%b rdata=%h",
                           i, adrs[i], av, ev, rv, nrd, nwr, !ref_ok(adrs[i]), ref_load(w, adrs[i]));
      end
      if (ref_ok(adrs[i]) && w) ref_mem[widx(adrs[i])] = 32'hCAFE0000 + 32'(i);
      model_last = logic'(p);
    end
  endtask

  task automatic test_tie_rr();
    int nacks = 0;
    logic exp_port;
    @(negedge clk); req = 2'b11; we = 2'b00; adr0 = 32'd1028; adr1 = 32'd1032;
    exp_port = ~model_last;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        checks++;
        if (ack !== (exp_port ? 2'b10 : 2'b01) || c != 3 * (nacks + 1)
            || rdata !== ref_mem[exp_port ? 2 : 1]) begin
          errors++; $display("FAIL tie_rr_%0d: ack=%b cycle=%0d rdata=%h, required port %0d at cycle %0d",
                             nacks, ack, c, rdata, exp_port, 3 * (nacks + 1));
        end
        model_last = exp_port; exp_port = ~exp_port; nacks++;
      end
    end
    req = 2'b00;
    checks++;
    if (nacks != 4) begin errors++; $display("FAIL tie_rr_count: acks=%0d required 4", nacks); end
  endtask

  task automatic test_tie_fixed();
    int nacks = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; model_last = 1'b1;
    @(negedge clk); req = 2'b11; we = 2'b00; adr0 = 32'd1028; adr1 = 32'd1032;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (ack_f != 2'b00) begin
        checks++;
        if (ack_f !== 2'b01 || c != 3 * (nacks + 1)) begin
          errors++; $display("FAIL tie_fixed_%0d: ack=%b cycle=%0d, required 01 at cycle %0d", nacks, ack_f, c, 3 * (nacks + 1));
        end
        nacks++;
      end
    end
    req = 2'b00;
    checks++;
    if (nacks != 4) begin errors++; $display("FAIL tie_fixed_count: acks=%0d required 4", nacks); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; model_last = 1'b1;
  endtask

  task automatic test_reset_store();
    logic [1:0] av; logic ev; logic [31:0] rv; int cyc, nrd, nwr;
    int stray = 0;
    @(negedge clk); req = 2'b10; we = 2'b10; adr1 = 32'd1200; wdata1 = 32'hA5A5_5A5A;
    @(posedge clk); #2;
    checks++;
    if (memWrite !== 1'b1) begin errors++; $display("FAIL rst_store_pre: memWrite=%b required 1", memWrite); end
    rst = 1'b0;
    #1;
    checks++;
    if (memWrite !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_store_drop: memWrite=%b busy=%b, required 0/0", memWrite, busy);
    end
    req = 2'b00;
    @(negedge clk); rst = 1'b1; model_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rst_store_noack: stray cycles=%0d required 0", stray); end
    run_txn(1, 1'b1, 32'd1200, 32'hA5A5_5A5A, av, ev, rv, cyc, nrd, nwr);
    ref_mem[widx(32'd1200)] = 32'hA5A5_5A5A; model_last = 1'b1;
    checks++;
    if (av !== 2'b10 || ev !== 1'b0 || nwr != 1) begin
      errors++; $display("FAIL rst_store_reissue: ack=%b err=%b writes=%0d, required 10/0/1", av, ev, nwr);
    end
    run_txn(0, 1'b0, 32'd1200, 32'd0, av, ev, rv, cyc, nrd, nwr);
    model_last = 1'b0;
    checks++;
    if (rv !== 32'hA5A5_5A5A) begin errors++; $display("FAIL rst_store_readback: rdata=%h required A5A55A5A", rv); end
  endtask

  task automatic test_random();
    logic [31:0] bad [6];
    logic [1:0] av; logic ev; logic [31:0] rv, a, d, exp_rd; int cyc, nrd, nwr, p;
    logic w; bit ok;
    bad = '{32'd1020, 32'd1280, 32'd1026, 32'd1023, 32'hFFFF_FFFC, 32'd0};
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(0, 1));
      w = logic'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 4) == 0) a = bad[$urandom_range(0, 5)];
      else a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      ok = ref_ok(a);
      exp_rd = ref_load(w, a);
      run_txn(p, w, a, d, av, ev, rv, cyc, nrd, nwr);
      checks++;
      if (av !== (p == 0 ? 2'b01 : 2'b10) || cyc != 3 || ev !== !ok || rv !== exp_rd
          || nrd != ((ok && !w) ? 1 : 0) || nwr != ((ok && w) ? 1 : 0)) begin
        errors++; $display("FAIL random_%0d p=%0d we=%b adr=%h: ack=%b cyc=%0d err=%b rdata=%h rd=%0d wr=%0d, required err=%b rdata=%h",
                           i, p, w, a, av, cyc, ev, rv, nrd, nwr, !ok, exp_rd);
      end
      if (ok && w) ref_mem[widx(a)] = d;
      model_last = logic'(p);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[1] = 32'hDEADBEEF;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = mem[i];
    test_reset();
    test_single_load();
    test_store_load();
    test_range();
    test_tie_rr();
    test_tie_fixed();
    test_reset_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
